// File: rtl/sksa_pkg.sv
// Shared types and constants for the sparse Kogge-Stone adder fault controller.
package sksa_pkg;

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} sksa_state_e;

  localparam int unsigned NIB_W = 4;
  localparam int unsigned N_NIB = 4;

  // Position of each adder carry tap in the captured tap vector
  localparam logic [1:0] TAP_C4   = 2'd0;
  localparam logic [1:0] TAP_C8   = 2'd1;
  localparam logic [1:0] TAP_C12  = 2'd2;
  localparam logic [1:0] TAP_COUT = 2'd3;

endpackage

// File: rtl/nibble_add4.sv
// Nibble-wide reference adder; reused once per CHECK cycle by the controller.
module nibble_add4
  import sksa_pkg::*;
(
  input  logic [NIB_W-1:0] a_i,
  input  logic [NIB_W-1:0] b_i,
  input  logic             cin_i,
  output logic [NIB_W-1:0] s_o,
  output logic             cout_o
);

  logic [NIB_W:0] sum;

  always_comb begin
    sum    = {1'b0, a_i} + {1'b0, b_i} + {{NIB_W{1'b0}}, cin_i};
    s_o    = sum[NIB_W-1:0];
    cout_o = sum[NIB_W];
  end

endmodule

// File: rtl/sksa_fault_ctrl.sv
// Drives the sparse adder, checks its sum and carry taps nibble by nibble against a
// reference adder, retries on mismatch and falls back to the reference result.
module sksa_fault_ctrl
  import sksa_pkg::*;
#(
  parameter int unsigned SETTLE_CYC   = 1,
  parameter int unsigned MAX_RETRY    = 2,
  parameter bit          STICKY_FAULT = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [NIB_W*N_NIB-1:0]   req_a,
  input  logic [NIB_W*N_NIB-1:0]   req_b,
  input  logic                     req_cin,
  output logic [NIB_W*N_NIB-1:0]   add_a,
  output logic [NIB_W*N_NIB-1:0]   add_b,
  output logic                     add_cin,
  input  logic [NIB_W*N_NIB-1:0]   add_s,
  input  logic                     add_c4,
  input  logic                     add_c8,
  input  logic                     add_c12,
  input  logic                     add_cout,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [NIB_W*N_NIB-1:0]   rsp_s,
  output logic                     rsp_cout,
  output logic                     rsp_fault,
  output logic [1:0]               rsp_retries,
  output logic [N_NIB-1:0]         fault_map,
  input  logic                     fault_clr
);

  localparam int unsigned W = NIB_W * N_NIB;

  sksa_state_e state_q, state_d;

  logic [W-1:0]     a_q, b_q, cap_s_q, ref_s_q, rsp_s_q;
  logic             cin_q, bypass_q, ref_c_q, rsp_cout_q, rsp_fault_q;
  logic [3:0]       settle_q;
  logic [1:0]       nib_q, retry_q;
  logic [N_NIB-1:0] mism_q, cap_tap_q, fault_map_q, fault_map_d;

  logic [3:0]       idx;
  logic [NIB_W-1:0] ref_nib_s;
  logic             ref_cin, ref_nib_c, nib_mism;
  logic [N_NIB-1:0] mism_all;
  logic [W-1:0]     ref_s_all;
  logic             last_nib, settle_done, use_bypass, retry_ok, retry_go, fail_set;

  assign idx         = {nib_q, 2'b00};
  assign ref_cin     = (nib_q == 2'd0) ? cin_q : ref_c_q;
  assign last_nib    = (nib_q == 2'd3);
  assign settle_done = (settle_q == 4'(SETTLE_CYC - 1));
  assign use_bypass  = STICKY_FAULT && (fault_map_q != '0);
  assign retry_ok    = (retry_q < 2'(MAX_RETRY));

  nibble_add4 u_ref (
    .a_i    (a_q[idx +: NIB_W]),
    .b_i    (b_q[idx +: NIB_W]),
    .cin_i  (ref_cin),
    .s_o    (ref_nib_s),
    .cout_o (ref_nib_c)
  );

  // Fold the nibble under check into the running results so the final CHECK edge
  // can decide on the complete mismatch vector and reference sum.
  always_comb begin
    nib_mism       = (cap_s_q[idx +: NIB_W] != ref_nib_s) || (cap_tap_q[nib_q] != ref_nib_c);
    mism_all       = mism_q;
    mism_all[nib_q] = mism_q[nib_q] | nib_mism;
    ref_s_all      = ref_s_q;
    ref_s_all[idx +: NIB_W] = ref_nib_s;
  end

  assign retry_go = (state_q == CHECK) && last_nib && !bypass_q && (mism_all != '0) && retry_ok;
  assign fail_set = (state_q == CHECK) && last_nib && !bypass_q && (mism_all != '0) && !retry_ok;

  // Clear drops old flags; a coincident set still records the newly flagged lanes.
  always_comb begin
    fault_map_d = fault_clr ? '0 : fault_map_q;
    if (fail_set) fault_map_d = fault_map_d | mism_all;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (req_valid) state_d = use_bypass ? CHECK : DRIVE;
      DRIVE: if (settle_done) state_d = CHECK;
      CHECK: if (last_nib) state_d = retry_go ? DRIVE : DONE;
      DONE:  if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      bypass_q    <= 1'b0;
      settle_q    <= '0;
      nib_q       <= '0;
      retry_q     <= '0;
      mism_q      <= '0;
      cap_s_q     <= '0;
      cap_tap_q   <= '0;
      ref_s_q     <= '0;
      ref_c_q     <= 1'b0;
      rsp_s_q     <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_fault_q <= 1'b0;
      fault_map_q <= '0;
    end else begin
      fault_map_q <= fault_map_d;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            a_q      <= req_a;
            b_q      <= req_b;
            cin_q    <= req_cin;
            bypass_q <= use_bypass;
            mism_q   <= '0;
            retry_q  <= '0;
            settle_q <= '0;
            nib_q    <= '0;
          end
        end
        DRIVE: begin
          if (settle_done) begin
            cap_s_q             <= add_s;
            cap_tap_q[TAP_C4]   <= add_c4;
            cap_tap_q[TAP_C8]   <= add_c8;
            cap_tap_q[TAP_C12]  <= add_c12;
            cap_tap_q[TAP_COUT] <= add_cout;
            settle_q            <= '0;
            nib_q               <= '0;
          end else begin
            settle_q <= settle_q + 4'd1;
          end
        end
        CHECK: begin
          ref_s_q <= ref_s_all;
          ref_c_q <= ref_nib_c;
          mism_q  <= mism_all;
          nib_q   <= nib_q + 2'd1;
          if (retry_go) begin
            retry_q  <= retry_q + 2'd1;
            mism_q   <= '0;
            settle_q <= '0;
          end else if (last_nib) begin
            if (bypass_q || (mism_all != '0)) begin
              rsp_s_q     <= ref_s_all;
              rsp_cout_q  <= ref_nib_c;
              rsp_fault_q <= 1'b1;
            end else begin
              rsp_s_q     <= cap_s_q;
              rsp_cout_q  <= cap_tap_q[TAP_COUT];
              rsp_fault_q <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready   = (state_q == IDLE);
    add_a       = '0;
    add_b       = '0;
    add_cin     = 1'b0;
    rsp_valid   = 1'b0;
    rsp_s       = '0;
    rsp_cout    = 1'b0;
    rsp_fault   = 1'b0;
    rsp_retries = '0;
    if (state_q == DRIVE) begin
      add_a   = a_q;
      add_b   = b_q;
      add_cin = cin_q;
    end
    if (state_q == DONE) begin
      rsp_valid   = 1'b1;
      rsp_s       = rsp_s_q;
      rsp_cout    = rsp_cout_q;
      rsp_fault   = rsp_fault_q;
      rsp_retries = retry_q;
    end
    fault_map = fault_map_q;
  end

endmodule

// File: tb/tb_sksa_fault_ctrl.sv
// Directed bench for sksa_fault_ctrl with a behavioural sparse adder that can inject faults.
module tb_sksa_fault_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0;
  int          errors = 0;

  // Instance 1: defaults (SETTLE_CYC=1, MAX_RETRY=2, STICKY_FAULT=1)
  logic        req_valid, req_ready, req_cin, add_cin, add_c4, add_c8, add_c12, add_cout;
  logic        rsp_valid, rsp_ready, rsp_cout, rsp_fault, fault_clr;
  logic [15:0] req_a, req_b, add_a, add_b, add_s, rsp_s;
  logic [1:0]  rsp_retries;
  logic [3:0]  fault_map;
  logic        swap2, inv4;

  // Instance 2: non-sticky, no retries
  logic        r2_valid, r2_ready, r2_cin, a2_cin, a2_c4, a2_c8, a2_c12, a2_cout;
  logic        s2_valid, s2_ready, s2_cout, s2_fault, clr2;
  logic [15:0] r2_a, r2_b, a2_a, a2_b, a2_s, s2_s;
  logic [1:0]  s2_retries;
  logic [3:0]  map2;
  logic        swap2_2, inv4_2;

  always #5 clk = ~clk;

  function automatic logic [19:0] adder_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic cin, input logic swap, input logic inv);
    logic [4:0] s0, s1, s2, s3;
    logic [3:0] bn2;
    bn2 = swap ? b[7:4] : b[11:8];
    s0  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, cin};
    s1  = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'b0, s0[4]};
    s2  = {1'b0, a[11:8]} + {1'b0, bn2} + {4'b0, s1[4]};
    s3  = {1'b0, a[15:12]} + {1'b0, b[15:12]} + {4'b0, s2[4]};
    return {s3[4], s2[4], s1[4], s0[4] ^ inv, s3[3:0], s2[3:0], s1[3:0], s0[3:0]};
  endfunction

  always_comb {add_cout, add_c12, add_c8, add_c4, add_s} = adder_model(add_a, add_b, add_cin,
                                                                       swap2, inv4);
  always_comb {a2_cout, a2_c12, a2_c8, a2_c4, a2_s} = adder_model(a2_a, a2_b, a2_cin,
                                                                 swap2_2, inv4_2);

  sksa_fault_ctrl u_dut (
    .clk (clk), .rst (rst),
    .req_valid (req_valid), .req_ready (req_ready),
    .req_a (req_a), .req_b (req_b), .req_cin (req_cin),
    .add_a (add_a), .add_b (add_b), .add_cin (add_cin),
    .add_s (add_s), .add_c4 (add_c4), .add_c8 (add_c8), .add_c12 (add_c12),
    .add_cout (add_cout),
    .rsp_valid (rsp_valid), .rsp_ready (rsp_ready),
    .rsp_s (rsp_s), .rsp_cout (rsp_cout), .rsp_fault (rsp_fault),
    .rsp_retries (rsp_retries), .fault_map (fault_map), .fault_clr (fault_clr)
  );

  sksa_fault_ctrl #(
    .SETTLE_CYC   (1),
    .MAX_RETRY    (0),
    .STICKY_FAULT (1'b0)
  ) u_dut2 (
    .clk (clk), .rst (rst),
    .req_valid (r2_valid), .req_ready (r2_ready),
    .req_a (r2_a), .req_b (r2_b), .req_cin (r2_cin),
    .add_a (a2_a), .add_b (a2_b), .add_cin (a2_cin),
    .add_s (a2_s), .add_c4 (a2_c4), .add_c8 (a2_c8), .add_c12 (a2_c12),
    .add_cout (a2_cout),
    .rsp_valid (s2_valid), .rsp_ready (s2_ready),
    .rsp_s (s2_s), .rsp_cout (s2_cout), .rsp_fault (s2_fault),
    .rsp_retries (s2_retries), .fault_map (map2), .fault_clr (clr2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request on instance 1 and wait (bounded) for rsp_valid.
  task automatic run1(input logic [15:0] a, input logic [15:0] b, input logic cin,
                      output int lat, output logic add_nz);
    req_a = a; req_b = b; req_cin = cin; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    add_nz = 1'b0;
    while (!rsp_valid && lat < 60) begin
      add_nz = add_nz | (add_a != 16'h0) | (add_b != 16'h0) | add_cin;
      @(posedge clk); #1;
      lat++;
      if (lat == 1) inv4 = 1'b0;
    end
  endtask

  task automatic finish1();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  int   lat;
  logic nz;

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_a = '0; req_b = '0; req_cin = 1'b0; rsp_ready = 1'b0;
    fault_clr = 1'b0; swap2 = 1'b0; inv4 = 1'b0;
    r2_valid = 1'b0; r2_a = '0; r2_b = '0; r2_cin = 1'b0; s2_ready = 1'b0;
    clr2 = 1'b0; swap2_2 = 1'b0; inv4_2 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check_eq("reset req_ready", req_ready, 1);
    check_eq("reset rsp_valid", rsp_valid, 0);
    check_eq("reset add_a", add_a, 0);
    check_eq("reset fault_map", fault_map, 0);

    // 1. basic carry propagation
    run1(16'h00FF, 16'h0001, 1'b0, lat, nz);
    check_eq("t1 latency", lat, 5);
    check_eq("t1 rsp_s", rsp_s, 16'h0100);
    check_eq("t1 cout", rsp_cout, 0);
    check_eq("t1 fault", rsp_fault, 0);
    check_eq("t1 retries", rsp_retries, 0);
    check_eq("t1 req_ready in DONE", req_ready, 0);
    finish1();
    check_eq("t1 back to idle", req_ready, 1);

    // 2. wrap and carry-in
    run1(16'hFFFF, 16'h0001, 1'b0, lat, nz);
    check_eq("t2a rsp_s", rsp_s, 16'h0000);
    check_eq("t2a cout", rsp_cout, 1);
    check_eq("t2a fault", rsp_fault, 0);
    finish1();
    run1(16'h7FFF, 16'h0000, 1'b1, lat, nz);
    check_eq("t2b rsp_s", rsp_s, 16'h8000);
    check_eq("t2b cout", rsp_cout, 0);
    finish1();

    // 3. transient c4 fault on first sample only
    inv4 = 1'b1;
    run1(16'h000F, 16'h0001, 1'b0, lat, nz);
    check_eq("t3 latency", lat, 10);
    check_eq("t3 rsp_s", rsp_s, 16'h0010);
    check_eq("t3 fault", rsp_fault, 0);
    check_eq("t3 retries", rsp_retries, 1);
    check_eq("t3 fault_map", fault_map, 0);
    finish1();

    // 4. persistent nibble-2 fault
    swap2 = 1'b1;
    run1(16'h0000, 16'h0F00, 1'b0, lat, nz);
    check_eq("t4 latency", lat, 15);
    check_eq("t4 rsp_s", rsp_s, 16'h0F00);
    check_eq("t4 fault", rsp_fault, 1);
    check_eq("t4 retries", rsp_retries, 2);
    check_eq("t4 fault_map", fault_map, 4'b0100);
    finish1();
    swap2 = 1'b0;

    // 5. sticky bypass with backpressure
    run1(16'h1111, 16'h2222, 1'b0, lat, nz);
    check_eq("t5 latency", lat, 4);
    check_eq("t5 add_* zero", nz, 0);
    check_eq("t5 rsp_s", rsp_s, 16'h3333);
    check_eq("t5 fault", rsp_fault, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("t5 hold valid", rsp_valid, 1);
      check_eq("t5 hold rsp_s", rsp_s, 16'h3333);
      check_eq("t5 hold fault", rsp_fault, 1);
      check_eq("t5 hold req_ready", req_ready, 0);
    end
    finish1();

    // 6. reset during CHECK (bypass op goes straight to CHECK)
    req_a = 16'h0101; req_b = 16'h0202; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("t6 req_ready", req_ready, 1);
    check_eq("t6 rsp_valid", rsp_valid, 0);
    check_eq("t6 fault_map", fault_map, 0);
    check_eq("t6 add_a", add_a, 0);
    run1(16'h1234, 16'h4321, 1'b1, lat, nz);
    check_eq("t6 post-reset latency", lat, 5);
    check_eq("t6 post-reset rsp_s", rsp_s, 16'h5556);
    check_eq("t6 post-reset fault", rsp_fault, 0);
    finish1();

    // 6b. instance 2: fault_clr coincident with a new fault set
    swap2_2 = 1'b1;
    r2_a = 16'h0000; r2_b = 16'h0F00; r2_cin = 1'b0; r2_valid = 1'b1;
    @(posedge clk); #1;
    r2_valid = 1'b0;
    lat = 0;
    while (!s2_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("t6b first latency", lat, 5);
    check_eq("t6b first fault_map", map2, 4'b0100);
    check_eq("t6b first rsp_s", s2_s, 16'h0F00);
    s2_ready = 1'b1;
    @(posedge clk); #1;
    s2_ready = 1'b0;
    swap2_2 = 1'b0;
    inv4_2  = 1'b1;
    r2_a = 16'h000F; r2_b = 16'h0001; r2_valid = 1'b1;
    @(posedge clk); #1;
    r2_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 clr2 = 1'b1;
    @(posedge clk); #1;
    clr2 = 1'b0;
    check_eq("t6b second valid", s2_valid, 1);
    check_eq("t6b clr+set fault_map", map2, 4'b0001);
    check_eq("t6b second rsp_s", s2_s, 16'h0010);
    check_eq("t6b second fault", s2_fault, 1);
    s2_ready = 1'b1;
    @(posedge clk); #1;
    s2_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
